// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared constants for the counter capture FIFO
package count_pkg;

    localparam int CNT_W_DEFAULT     = 4;
    localparam int CAP_DEPTH_DEFAULT = 4;

    // Position of the wrap tag inside a stored entry: the bit just above the count.
    function automatic int tag_bit(input int width);
        return width;
    endfunction

    // Occupancy counter width: enough to hold the value DEPTH itself.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/capture_fifo_core.sv
// rtl/capture_fifo_core.sv - FIFO storage, pointers, occupancy and valid/ready head port
module capture_fifo_core
    import count_pkg::*;
#(
    parameter int DW    = CNT_W_DEFAULT + 1,
    parameter int DEPTH = CAP_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push_i,
    input  logic [DW-1:0]                 wr_data_i,
    input  logic                          pop_ready_i,
    output logic [DW-1:0]                 out_data_o,
    output logic                          out_valid_o,
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop;

    // A pop only happens when there is a head to hand over.
    assign pop = pop_ready_i & (level_q != '0);

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state clears asynchronously; stored entries are left as-is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; when full with a same-cycle pop the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign out_valid_o = (level_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o     = level_q;
    assign full_o      = (level_q == LVL_W'(DEPTH));
    assign empty_o     = (level_q == '0);

endmodule

// File: rtl/count_capture_fifo.sv
// rtl/count_capture_fifo.sv - samples a free-running counter with wrap tag into a small FIFO
module count_capture_fifo
    import count_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT,
    parameter int DEPTH = CAP_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [WIDTH-1:0]          cnt_in,
    input  logic                      capture,
    output logic [WIDTH:0]            out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    input  logic                      ovf_clr,
    output logic                      wrap
);

    localparam int TAG_BIT = tag_bit(WIDTH);

    logic [WIDTH-1:0] prev_cnt_q;
    logic             wrap_q, wrap_d;
    logic             wrap_pend_q, wrap_pend_d;
    logic             overflow_q, overflow_d;
    logic             wrap_now;
    logic             pop;
    logic             push;
    logic             drop;
    logic [WIDTH:0]   entry;

    // Wrap is the all-ones to zero transition between consecutive samples.
    assign wrap_now = (prev_cnt_q == {WIDTH{1'b1}}) && (cnt_in == '0);

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign pop  = out_valid & out_ready;
    assign push = capture & (~full | pop);
    assign drop = capture & ~push;

    // Entry: tag carries any wrap seen since the last accepted capture, including this cycle.
    always_comb begin
        entry                 = '0;
        entry[WIDTH-1:0]      = cnt_in;
        entry[TAG_BIT]        = wrap_pend_q | wrap_now;
    end

    // Pending wrap, sticky overflow and the delayed wrap pulse.
    always_comb begin
        wrap_d      = wrap_now;
        wrap_pend_d = wrap_pend_q;
        overflow_d  = overflow_q;
        if (push) begin
            wrap_pend_d = 1'b0;
        end else if (wrap_now) begin
            wrap_pend_d = 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Top-level state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_cnt_q  <= '0;
            wrap_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            prev_cnt_q  <= cnt_in;
            wrap_q      <= wrap_d;
            wrap_pend_q <= wrap_pend_d;
            overflow_q  <= overflow_d;
        end
    end

    capture_fifo_core #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_core (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .wr_data_i   (entry),
        .pop_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign overflow = overflow_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// tb/tb_count_capture_fifo.sv - self-checking bench for count_capture_fifo
module tb_count_capture_fifo;

    localparam int W = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic [W-1:0]   cnt_in;
    logic           capture;
    logic [W:0]     out_data;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     level;
    logic           full;
    logic           empty;
    logic           overflow;
    logic           ovf_clr;
    logic           wrap;

    int checks = 0;
    int failures = 0;

    count_capture_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cnt_in    (cnt_in),
        .capture   (capture),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of tagged samples plus sticky flags.
    logic [W:0]   m_q [$];
    logic [W-1:0] m_prev;
    logic         m_pend;
    logic         m_ovf;
    logic         m_wrap;

    always @(posedge clk or negedge rstn) begin : model
        logic can_pop, take, wn;
        if (!rstn) begin
            m_q.delete();
            m_prev = '0;
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            m_wrap = 1'b0;
        end else begin
            can_pop = (m_q.size() > 0) && out_ready;
            wn      = (m_prev == 4'd15) && (cnt_in == 4'd0);
            take    = capture && ((m_q.size() < D) || can_pop);
            if (can_pop) void'(m_q.pop_front());
            if (take) m_q.push_back({m_pend | wn, cnt_in});
            if (take) m_pend = 1'b0;
            else if (wn) m_pend = 1'b1;
            if (capture && !take) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_wrap = wn;
            m_prev = cnt_in;
        end
    end

    always @(negedge clk) begin
        check("cmp_valid", int'(out_valid), int'(m_q.size() != 0));
        if (m_q.size() != 0) check("cmp_data", int'(out_data), int'(m_q[0]));
        check("cmp_level", int'(level), m_q.size());
        check("cmp_full", int'(full), int'(m_q.size() == D));
        check("cmp_empty", int'(empty), int'(m_q.size() == 0));
        check("cmp_overflow", int'(overflow), int'(m_ovf));
        check("cmp_wrap", int'(wrap), int'(m_wrap));
    end

    initial begin
        cnt_in = '0; capture = 0; out_ready = 0; ovf_clr = 0;
        #1 rstn = 0;
        step(); step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_overflow", overflow, 0);
        check("rst_wrap", wrap, 0);
        rstn = 1;

        // First capture into empty FIFO, then hold with out_ready low.
        cnt_in = 4'd5; capture = 1; step(); capture = 0;
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 5'h05);
        check("t1_level", level, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t1_hold", out_data, 5'h05);
        end
        out_ready = 1; step(); out_ready = 0;
        check("t1_empty", empty, 1);

        // Wrap detection and tagging.
        cnt_in = 4'd14; step();
        cnt_in = 4'd15; step();
        cnt_in = 4'd0;  step();
        check("t2_wrap_hi", wrap, 1);
        cnt_in = 4'd1;  step();
        check("t2_wrap_lo", wrap, 0);
        cnt_in = 4'd3; capture = 1; step(); capture = 0;
        check("t2_tag", out_data, 5'h13);
        cnt_in = 4'd4; capture = 1; out_ready = 1; step(); capture = 0; out_ready = 0;
        check("t2_notag", out_data, 5'h04);
        check("t2_level", level, 1);
        out_ready = 1; step(); out_ready = 0;

        // Fill, overflow drop, drain order.
        capture = 1;
        for (int v = 1; v <= 4; v++) begin
            cnt_in = W'(v); step();
        end
        capture = 0;
        check("t3_full", full, 1);
        check("t3_level", level, 4);
        cnt_in = 4'd9; capture = 1; step(); capture = 0;
        check("t3_overflow", overflow, 1);
        check("t3_level_drop", level, 4);
        out_ready = 1;
        for (int v = 1; v <= 4; v++) begin
            check("t3_drain", out_data, v);
            step();
        end
        out_ready = 0;
        check("t3_empty", empty, 1);

        // Clear overflow.
        ovf_clr = 1; step(); ovf_clr = 0;
        check("t5_clr", overflow, 0);

        // Full with simultaneous push and pop.
        capture = 1;
        for (int v = 10; v <= 13; v++) begin
            cnt_in = W'(v); step();
        end
        capture = 0;
        check("t4_full", full, 1);
        cnt_in = 4'd7; capture = 1; out_ready = 1; step(); capture = 0; out_ready = 0;
        check("t4_level", level, 4);
        check("t4_overflow", overflow, 0);
        check("t4_head", out_data, 5'h0b);
        out_ready = 1;
        check("t4_d0", out_data, 5'h0b); step();
        check("t4_d1", out_data, 5'h0c); step();
        check("t4_d2", out_data, 5'h0d); step();
        check("t4_tail", out_data, 5'h07); step();
        out_ready = 0;

        // Drop and clear in the same cycle: set wins.
        capture = 1;
        for (int v = 1; v <= 4; v++) begin
            cnt_in = W'(v); step();
        end
        cnt_in = 4'd8; ovf_clr = 1; step(); capture = 0; ovf_clr = 0;
        check("t5_setwins", overflow, 1);
        ovf_clr = 1; step(); ovf_clr = 0;
        check("t5_clr2", overflow, 0);
        out_ready = 1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 0;
        check("t5_empty", empty, 1);

        // Asynchronous reset mid-cycle with three entries and a pending wrap.
        capture = 1;
        for (int v = 1; v <= 3; v++) begin
            cnt_in = W'(v); step();
        end
        capture = 0;
        cnt_in = 4'd15; step();
        cnt_in = 4'd0;  step();
        check("t6_level_pre", level, 3);
        #2 rstn = 0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_empty", empty, 1);
        check("t6_level", level, 0);
        step();
        rstn = 1;
        cnt_in = 4'd2; capture = 1; step(); capture = 0;
        check("t6_notag", out_data, 5'h02);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Downstream consumer of the free-running counters (`counter_4bit`, `counter_3bit`, `counter_2bit`). It samples the counter value on a capture strobe, tags each sample with a "wrapped since last capture" bit, and buffers the samples in a small FIFO. Samples drain through a valid/ready output port to the next stage. It sits between a counter and any logging or readback logic.

## Interface
Parameters:
- `WIDTH`, default 4: counter width; set to 4, 3 or 2 to match the attached counter.
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1  rising-edge clock
- `rstn`  in  1  reset; asynchronous assert, active-low
- `cnt_in`  in  WIDTH  counter output, sampled every cycle
- `capture`  in  1  push request, sampled at the clock edge
- `out_data`  out  WIDTH+1  head entry `{wrap_tag, count}`
- `out_valid`  out  1  head entry present
- `out_ready`  in  1  consumer accepts the head
- `level`  out  clog2(DEPTH)+1  occupancy
- `full`  out  1  level == DEPTH
- `empty`  out  1  level == 0
- `overflow`  out  1  sticky: a capture was dropped
- `ovf_clr`  in  1  clears `overflow`
- `wrap`  out  1  one-cycle pulse on counter wrap-around

## Operation
- Reset values: `out_data` = 0, `out_valid` = 0, `level` = 0, `full` = 0, `empty` = 1, `overflow` = 0, `wrap` = 0. Internal state also clears: `prev_cnt` = 0, `wrap_pend` = 0, pointers = 0.
- Wrap detect:
  - `prev_cnt` registers `cnt_in` every cycle.
  - `wrap` = 1 in the cycle after the edge where `prev_cnt` == all-ones and `cnt_in` == 0.
  - No `wrap` pulse is generated by reset itself.
- `wrap_pend`:
  - Set whenever a wrap is detected.
  - Cleared by an accepted capture.
  - A wrap detected in the same cycle as an accepted capture is tagged into that entry, and `wrap_pend` ends at 0.
- Push: `capture` = 1 and (not `full`, or a pop in the same cycle) writes `{wrap_pend | wrap_now, cnt_in}` at the write pointer.
- Pop: `out_valid` && `out_ready` advances the read pointer.
- Simultaneous push and pop:
  - When full: both happen and `level` is unchanged.
  - When empty: the push happens and the pop is impossible (`out_valid` = 0).
- Overflow:
  - A capture while full with no pop is dropped.
  - `overflow` sets and `wrap_pend` is preserved.
  - `ovf_clr` clears `overflow`. If a drop happens in the same cycle, set wins.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. `level` tracks occupancy separately.
- `out_data` is the registered memory head, valid only while `out_valid` = 1. It holds its value while `out_ready` = 0.
- Reset mid-operation: asynchronous clear of all state. FIFO contents are discarded and need no clearing, because `out_valid` = 0.

## Timing
- Capture latency: `capture` at edge N gives `out_valid` = 1 after edge N (first entry into an empty FIFO). There is no combinational path from `capture` to the outputs.
- `out_valid` and `out_data` do not depend combinationally on `out_ready`.
- Pop effect: the next entry appears after the accepting edge. Back-to-back pops sustain 1 entry/cycle.
- `full`, `empty` and `level` update on the same edge as the push/pop that changes them.
- `wrap`: 1-cycle pulse, one cycle after the wrapping edge of `cnt_in`.

## Structure
- Shared package/header `count_pkg`:
  - `CNT_W_DEFAULT` = 4
  - `CAP_DEPTH_DEFAULT` = 4
  - entry layout constant `TAG_BIT` = WIDTH (MSB of the entry)
- Sub-module `capture_fifo_core`: storage, pointers, `level`, `full`/`empty`, valid/ready output.
- The top level holds wrap detect, `wrap_pend`, overflow logic and entry formation.

## Test plan
- Reset, then `capture` at `cnt_in` = 5 with `out_ready` = 0:
  - One cycle later, `out_valid` = 1, `out_data` = 0x05, `level` = 1.
  - Data holds for 10 cycles.
- Drive `cnt_in` 14, 15, 0, 1 (WIDTH = 4):
  - `wrap` pulses once, the cycle after 0 is sampled.
  - A capture at `cnt_in` = 3 then yields `out_data` = 0x13.
  - The next capture at 4 yields 0x04.
- Capture 4 times (values 1, 2, 3, 4) with `out_ready` = 0:
  - `full` = 1 and `level` = 4.
  - A fifth capture (value 9) is dropped and `overflow` = 1.
  - Drain order is 1, 2, 3, 4, then `empty` = 1.
- Full FIFO with `capture` and `out_ready` both high, `cnt_in` = 7:
  - `level` stays 4.
  - After the head pops, the tail contains 7.
  - `overflow` stays 0.
- `overflow` = 1:
  - Pulse `ovf_clr`: `overflow` = 0.
  - `ovf_clr` in the same cycle as a dropped capture: `overflow` stays 1.
- Assert `rstn` = 0 mid-cycle with `level` = 3:
  - Immediately `out_valid` = 0, `empty` = 1, `level` = 0, with no clock edge needed.
  - After release, the first capture of 2 reads back 0x02 (no stale tag).
